// File: rtl/axis_in_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_in_fifo_if
//  Description : Valid/ready/last/data stream bundle. It carries both the
//                incoming AXI-Stream and the outgoing FIR sample stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_in_fifo_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   tvalid;
    logic [pDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic                   tready;

    // The producer drives valid/data/last and observes ready
    modport master (output tvalid, output tdata, output tlast, input tready);
    // The consumer observes valid/data/last and drives ready
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_in_fifo
//  Description : AXI-Stream slave front end for the FIR dataflow core.
//                Incoming beats go into a first-word-fall-through FIFO.
//                A programmed beat count ends each run. TLAST is checked
//                against that count, and any mismatch sets a sticky error.
//                A finish pulse is issued once the FIFO has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_in_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 4,
    parameter int pLEN_WIDTH  = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          ap_start,
    input  wire logic [pLEN_WIDTH-1:0]         data_length,
    axis_in_fifo_if.slave                      axis,
    axis_in_fifo_if.master                     strm,
    output logic                               axis_finish,
    output logic                               tlast_err,
    output logic [$clog2(pDEPTH+1)-1:0]        level
);

    localparam int c_PTR_W = $clog2(pDEPTH);
    localparam int c_LVL_W = $clog2(pDEPTH + 1);
    localparam logic [pLEN_WIDTH-1:0] c_LEN_ONE = pLEN_WIDTH'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0]    c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0]    c_LVL_MAX = c_LVL_W'(pDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_finish_nxt;

    // Each FIFO entry holds {last flag, sample}
    logic [pDATA_WIDTH:0]    r_mem [pDEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_LVL_W-1:0]      r_level;
    logic [pLEN_WIDTH-1:0]   r_len;
    logic [pLEN_WIDTH-1:0]   r_cnt;
    logic                    r_finish;
    logic                    r_tlast_err;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_tready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_beat;
    logic                    w_start;
    logic [pDATA_WIDTH:0]    w_head;

    assign w_full      = (r_level == c_LVL_MAX);
    assign w_empty     = (r_level == '0);
    // Ready depends only on FIFO space, so a pop in the same cycle
    // cannot open room for a push.
    assign w_tready    = (r_state == RUN) && !w_full;
    assign w_push      = axis.tvalid && w_tready;
    assign w_pop       = !w_empty && strm.tready;
    assign w_last_beat = (r_cnt == (r_len - c_LEN_ONE));
    assign w_start     = (r_state == IDLE) && ap_start;
    assign w_head      = r_mem[r_rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the finish condition is registered separately
    always_comb begin
        w_state_nxt  = r_state;
        w_finish_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (ap_start) begin
                    w_state_nxt = (data_length == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (w_push && w_last_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_finish_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Run bookkeeping: latch the length, count beats, track TLAST mismatches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_tlast_err <= 1'b0;
        end else if (w_start) begin
            r_len       <= data_length;
            r_cnt       <= '0;
            r_tlast_err <= 1'b0;
        end else if (w_push) begin
            r_cnt <= r_cnt + c_LEN_ONE;
            if (axis.tlast != w_last_beat) begin
                r_tlast_err <= 1'b1;
            end
        end
    end

    // FIFO storage; the contents need no reset because level gates the reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last_beat, axis.tdata};
        end
    end

    // FIFO pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // One-cycle completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_finish <= 1'b0;
        end else begin
            r_finish <= w_finish_nxt;
        end
    end

    assign axis.tready = w_tready;
    assign strm.tvalid = !w_empty;
    assign strm.tdata  = w_empty ? '0 : w_head[pDATA_WIDTH-1:0];
    assign strm.tlast  = !w_empty && w_head[pDATA_WIDTH];
    assign axis_finish = r_finish;
    assign tlast_err   = r_tlast_err;
    assign level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_axis_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_in_fifo
//  Description : Scoreboard bench for axis_in_fifo. Each beat is queued
//                with its expected last flag when it is offered. A monitor
//                pops the queue on every FIR-side handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_in_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = 16;
    localparam int LVLW  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ap_start = 1'b0;
    logic [LW-1:0]   data_length = '0;
    logic            axis_finish;
    logic            tlast_err;
    logic [LVLW-1:0] level;

    axis_in_fifo_if #(.pDATA_WIDTH(DW)) axis_bus ();
    axis_in_fifo_if #(.pDATA_WIDTH(DW)) strm_bus ();

    axis_in_fifo #(
        .pDATA_WIDTH (DW),
        .pDEPTH      (DEPTH),
        .pLEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ap_start    (ap_start),
        .data_length (data_length),
        .axis        (axis_bus.slave),
        .strm        (strm_bus.master),
        .axis_finish (axis_finish),
        .tlast_err   (tlast_err),
        .level       (level)
    );

    always #5 clk = ~clk;

    int          checks  = 0;
    int          errors  = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] mon_e;
    int          fin_cnt = 0;
    time         t_fin   = 0;
    logic        prev_fin = 1'b0;
    int          fr_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIR-side ready generator
    initial begin
        strm_bus.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (fr_mode)
                0:       strm_bus.tready = 1'b1;
                1:       strm_bus.tready = ($urandom_range(0, 3) != 0);
                default: strm_bus.tready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, idle-output checks, finish tracking
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fin = 1'b0;
        end else begin
            if (strm_bus.tvalid && strm_bus.tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, strm_bus.tlast, strm_bus.tdata}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strm_data", strm_bus.tdata, mon_e[DW-1:0]);
                    chk("strm_last", strm_bus.tlast, mon_e[DW]);
                end
            end
            if (!strm_bus.tvalid) begin
                chk("idle_output", {strm_bus.tlast, strm_bus.tdata}, 0);
            end
            chk("level_bound", level <= DEPTH, 1);
            if (axis_finish) begin
                fin_cnt++;
                t_fin = $time;
                chk("finish_drained", exp_q.size(), 0);
                chk("finish_single", prev_fin, 0);
            end
            prev_fin = axis_finish;
        end
    end

    // One complete run: program the length, offer len beats, await finish
    task automatic do_run(input int len, input int tlast_pos, input bit seq,
                          input bit gaps, input bit mid_start, input bit timed);
        logic [DW-1:0] d[$];
        bit            exp_err;
        bit            ok;
        int            f0;
        time           t_start;
        exp_err = (tlast_pos != len - 1);
        for (int i = 0; i < len; i++) d.push_back(seq ? DW'(i + 1) : DW'($urandom()));
        f0 = fin_cnt;
        @(posedge clk); #1;
        ap_start    = 1'b1;
        data_length = LW'(len);
        @(posedge clk);
        t_start = $time;
        #1;
        ap_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    axis_bus.tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (mid_start && i == 3) begin
                axis_bus.tvalid = 1'b0;
                ap_start        = 1'b1;
                data_length     = LW'(3);
                @(posedge clk); #1;
                ap_start = 1'b0;
            end
            axis_bus.tvalid = 1'b1;
            axis_bus.tdata  = d[i];
            axis_bus.tlast  = (i == tlast_pos);
            exp_q.push_back({(i == len - 1), d[i]});
            ok = 1'b0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (i == 0 && k == 0) chk("err_cleared", tlast_err, 0);
                if (axis_bus.tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            if (!ok) begin
                chk("tready_timeout", 0, 1);
                axis_bus.tvalid = 1'b0;
                return;
            end
        end
        axis_bus.tvalid = 1'b0;
        axis_bus.tlast  = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (fin_cnt > f0) break;
            @(negedge clk);
        end
        chk("finish_count", fin_cnt, f0 + 1);
        if (timed) chk("finish_time", t_fin - t_start, (len + 2) * 10 + 5);
        chk("tlast_err", tlast_err, exp_err);
        chk("level_end", level, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        axis_bus.tvalid = 1'b0;
        axis_bus.tdata  = '0;
        axis_bus.tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tready", axis_bus.tready, 0);
        chk("rst_valid", strm_bus.tvalid, 0);
        chk("rst_data", strm_bus.tdata, 0);
        chk("rst_last", strm_bus.tlast, 0);
        chk("rst_level", level, 0);
        chk("rst_finish", axis_finish, 0);
        chk("rst_err", tlast_err, 0);

        // Basic back-to-back run of 11 beats with exact completion timing
        do_run(11, 10, 1'b1, 1'b0, 1'b0, 1'b1);

        // Backpressure: FIR stalled until the FIFO fills
        fr_mode = 2;
        fork
            do_run(8, 7, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                repeat (8) @(negedge clk);
                chk("bp_level", level, DEPTH);
                chk("bp_tready", axis_bus.tready, 0);
                repeat (2) @(negedge clk);
                fr_mode = 0;
            end
        join

        // Early TLAST, then a clean run, then a run with no TLAST at all
        do_run(8, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        do_run(5, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        do_run(8, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero length: finish two cycles after the start cycle, no traffic
        f0 = fin_cnt;
        @(posedge clk); #1;
        ap_start    = 1'b1;
        data_length = '0;
        @(negedge clk);
        chk("zl_tready_c0", axis_bus.tready, 0);
        chk("zl_finish_c0", axis_finish, 0);
        @(posedge clk); #1;
        ap_start = 1'b0;
        @(negedge clk);
        chk("zl_tready_c1", axis_bus.tready, 0);
        chk("zl_finish_c1", axis_finish, 0);
        chk("zl_err_cleared", tlast_err, 0);
        @(negedge clk);
        chk("zl_finish_c2", axis_finish, 1);
        chk("zl_valid", strm_bus.tvalid, 0);
        @(negedge clk);
        chk("zl_finish_c3", axis_finish, 0);
        chk("zl_fin_count", fin_cnt, f0 + 1);

        // Reset after 3 of 8 beats, then a fresh run
        fr_mode = 2;
        @(posedge clk); #1;
        ap_start    = 1'b1;
        data_length = LW'(8);
        @(posedge clk); #1;
        ap_start        = 1'b0;
        axis_bus.tvalid = 1'b1;
        axis_bus.tdata  = 32'hA5;
        axis_bus.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mr_level_pre", level, 3);
        rst_n           = 1'b0;
        axis_bus.tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_level", level, 0);
        chk("mr_valid", strm_bus.tvalid, 0);
        chk("mr_tready", axis_bus.tready, 0);
        fr_mode = 0;
        do_run(6, 5, 1'b1, 1'b0, 1'b0, 1'b0);

        // ap_start pulsed mid-run with a different length is ignored
        do_run(7, 6, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized runs with gaps, random FIR stalls and random TLAST faults
        fr_mode = 1;
        for (int r = 0; r < 20; r++) begin
            int len;
            int tp;
            len = int'($urandom_range(1, 12));
            tp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) - 1 : len - 1;
            do_run(len, tp, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        fr_mode = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_in_fifo.md
Name: axis_in_fifo

Overview:
Parametrised AXI-Stream slave front end for the FIR dataflow core. It accepts an input stream, buffers up to pDEPTH samples in a first-word-fall-through FIFO, and presents them to the FIR core over a valid/ready handshake. Stream length is programmed per run and enforced by a beat counter. TLAST is checked against that length, with a sticky error flag. Completion is signalled once the final sample has been consumed by the FIR core.

Parameters:
pDATA_WIDTH, 32, sample width in bits
pDEPTH, 4, FIFO depth in samples; power of two, minimum 2
pLEN_WIDTH, 16, width of the programmed stream length

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
ap_start  in  1  one-cycle run start pulse
data_length  in  pLEN_WIDTH  expected beat count; sampled on ap_start
tvalid  in  1  AXIS valid
tdata  in  pDATA_WIDTH  AXIS data
tlast  in  1  AXIS last
tready  out  1  AXIS ready
strm_data  out  pDATA_WIDTH  FIFO head sample to FIR
strm_valid  out  1  FIFO head valid
strm_last  out  1  head is the final sample of the run
fir_ready  in  1  FIR accepts the head sample
axis_finish  out  1  one-cycle pulse: run complete, FIFO drained
tlast_err  out  1  sticky TLAST/length mismatch
level  out  $clog2(pDEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge) clears the state to IDLE, the FIFO pointers, level, the beat counter, axis_finish and tlast_err. Outputs then read tready=0, strm_valid=0, strm_data=0, strm_last=0, level=0. Reset mid-run discards all buffered data.
- The FSM has three states: IDLE, RUN, DRAIN.
  - IDLE: tready=0. On ap_start, latch data_length into len_q and clear cnt. If data_length=0 go to DRAIN, else go to RUN. Clear tlast_err.
  - RUN: tready = !full (independent of fir_ready; no push into a full FIFO even if a pop occurs in the same cycle). A push occurs on tvalid && tready. Each push stores {tdata, cnt==len_q-1} and increments cnt. The push with cnt==len_q-1 moves the FSM to DRAIN.
  - DRAIN: tready=0. When the FIFO is empty, register axis_finish=1 for exactly one cycle and return to IDLE.
- ap_start is ignored in RUN and DRAIN.
- TLAST check on every push:
  - tlast=1 while cnt!=len_q-1 sets tlast_err.
  - tlast=0 on the beat with cnt==len_q-1 sets tlast_err.
  - tlast_err holds until the next accepted ap_start or reset.
  - The length counter, not tlast, terminates the run.
- FIFO output:
  - strm_valid = !empty. strm_data and strm_last are combinational from the head entry and are forced to 0 when empty.
  - A pop occurs on strm_valid && fir_ready.
  - Latency: a beat pushed at edge N is visible on strm_valid after edge N (one cycle). No bubble under continuous flow with fir_ready=1.
- Pointers are log2(pDEPTH) bits and wrap modulo pDEPTH.
- level is an up/down counter: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. full = (level==pDEPTH); empty = (level==0).
- Pushes are possible only in RUN, so level never exceeds pDEPTH and never underflows.

Test Plan:
- Basic run: data_length=11, tdata=1..11, tlast on beat 11, tvalid=1 and fir_ready=1 throughout → strm_data is 1..11 in order, strm_last=1 only with 11, axis_finish pulses one cycle after the cycle where the FIFO becomes empty in DRAIN, tlast_err=0.
- Backpressure: data_length=8, fir_ready=0 for 10 cycles, then 1 → tready falls after 4 pushes, level=4, no beat lost or duplicated, output order is 1..8.
- Early and missing TLAST:
  - data_length=8 with tlast on beat 5 → tlast_err=1; all 8 beats are still accepted and finish occurs normally.
  - Next ap_start clears tlast_err.
  - A run with no tlast at all sets tlast_err=1 on beat 8.
- Zero length: ap_start with data_length=0 → no tready assertion, axis_finish high 2 cycles after the ap_start cycle, strm_valid stays 0.
- Reset mid-run: assert rst_n=0 for one posedge after 3 of 8 beats are pushed → next cycle shows level=0, strm_valid=0, tready=0, state IDLE. A fresh run then completes correctly.
- ap_start during RUN is ignored: len_q and cnt are unchanged, and the run ends after the originally programmed length.
